// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: control inputs, instruction-memory port and IF/ID outputs.
// The fetch unit connects through master; the surrounding pipeline/memory uses slave.
interface pc_fetch_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OFF_W   = 16,
  parameter int unsigned COUNT_W = 16
);
  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [OFF_W-1:0]   branch_offset;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic               ifid_valid;
  logic               running;
  logic               halted;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    input  start, stall, branch_taken, branch_offset, jump, jump_target, imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, running, halted, fetch_count
  );

  modport slave (
    output start, stall, branch_taken, branch_offset, jump, jump_target, imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, running, halted, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID register with jump/branch redirect, stall and halt-opcode stop.
// imem_addr is the PC register itself, so memory reads are combinational from state only.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OP  = 6'h3F,
  parameter int unsigned       COUNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  pc_fetch_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  pc, pc_nx;
  logic [INSTR_W-1:0] instr_q, instr_nx;
  logic [ADDR_W-1:0]  ipc_q, ipc_nx;
  logic               valid_q, valid_nx;
  logic [COUNT_W-1:0] cnt_q, cnt_nx;
  logic [ADDR_W-1:0]  br_target;
  logic               is_halt;

  // Sign-extending (or truncating) cast keeps the target modulo 2^ADDR_W for any OFF_W.
  assign br_target = ipc_q + ADDR_W'(1) + ADDR_W'(signed'(bus.branch_offset));
  assign is_halt   = (bus.imem_data[INSTR_W-1 -: 6] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      instr_q <= instr_nx;
      ipc_q   <= ipc_nx;
      valid_q <= valid_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr_q;
    ipc_nx   = ipc_q;
    valid_nx = valid_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (bus.start) state_nx = RUN;
      end
      RUN: begin
        if (bus.jump) begin
          pc_nx    = bus.jump_target;
          valid_nx = 1'b0;
        end else if (bus.branch_taken) begin
          pc_nx    = br_target;
          valid_nx = 1'b0;
        end else if (!bus.stall) begin
          instr_nx = bus.imem_data;
          ipc_nx   = pc;
          valid_nx = 1'b1;
          cnt_nx   = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);
          // The halt word itself is delivered; only the PC stops advancing.
          if (is_halt) state_nx = HALTED;
          else         pc_nx    = pc + ADDR_W'(1);
        end
      end
      HALTED: valid_nx = 1'b0;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc     = ipc_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.running     = (state == RUN);
  assign bus.halted      = (state == HALTED);
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table plus halt and saturation sequences.
// Instruction memory holds its own address at every location unless a test overrides a word.
module tb_pc_fetch_unit;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_W(AW), .INSTR_W(IW), .OFF_W(OW), .COUNT_W(CW)) bus ();

  pc_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .OFF_W(OW), .RESET_PC(8'h00), .HALT_OP(6'h3F), .COUNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [IW-1:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

  typedef struct {
    logic        r, s, st, b;
    logic [15:0] o;
    logic        j;
    logic [7:0]  t;
    logic [7:0]  pc, ipc;
    logic        vld, run, hlt;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic r, s, st, b, logic [15:0] o, logic j, logic [7:0] t,
                              logic [7:0] pc, ipc, logic vld, run, hlt, logic [3:0] cnt);
    vec_t x;
    x.r = r; x.s = s; x.st = st; x.b = b; x.o = o; x.j = j; x.t = t;
    x.pc = pc; x.ipc = ipc; x.vld = vld; x.run = run; x.hlt = hlt; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, st, b, input logic [15:0] o, input logic j,
                       input logic [7:0] t);
    rst               = r;
    bus.start         = s;
    bus.stall         = st;
    bus.branch_taken  = b;
    bus.branch_offset = o;
    bus.jump          = j;
    bus.jump_target   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"},      32'(bus.imem_addr),   32'h0);
    chk({tag, " ifid_pc"}, 32'(bus.ifid_pc),     32'h0);
    chk({tag, " instr"},   bus.ifid_instr,       32'h0);
    chk({tag, " valid"},   32'(bus.ifid_valid),  32'h0);
    chk({tag, " running"}, 32'(bus.running),     32'h0);
    chk({tag, " halted"},  32'(bus.halted),      32'h0);
    chk({tag, " count"},   32'(bus.fetch_count), 32'h0);
  endtask

  initial begin
    for (int unsigned a = 0; a < 256; a++) mem[a] = 32'(a);
    drive(1, 0, 0, 0, 16'h0, 0, 8'h0);

    //                 r  s st  b  off      j  jt    | pc   ipc  v  run h cnt
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd0,   8'd0,   0, 0, 0, 4'd0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd0,   8'd0,   0, 0, 0, 4'd0));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 8'd0,   8'd0,   8'd0,   0, 1, 0, 4'd0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd1,   8'd0,   1, 1, 0, 4'd1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd2,   8'd1,   1, 1, 0, 4'd2));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd3,   8'd2,   1, 1, 0, 4'd3));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd4,   8'd3,   1, 1, 0, 4'd4));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd5,   8'd4,   1, 1, 0, 4'd5));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd6,   8'd5,   1, 1, 0, 4'd6));
    vt.push_back(mk(0, 0, 0, 1, 16'hFFFD, 0, 8'd0,   8'd3,   8'd5,   0, 1, 0, 4'd6));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd4,   8'd3,   1, 1, 0, 4'd7));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd5,   8'd4,   1, 1, 0, 4'd8));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd6,   8'd5,   1, 1, 0, 4'd9));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd7,   8'd6,   1, 1, 0, 4'd10));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd8,   8'd7,   1, 1, 0, 4'd11));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd9,   8'd8,   1, 1, 0, 4'd12));
    vt.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 8'd0,   8'd9,   8'd8,   1, 1, 0, 4'd12));
    vt.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 8'd0,   8'd9,   8'd8,   1, 1, 0, 4'd12));
    vt.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 8'd0,   8'd9,   8'd8,   1, 1, 0, 4'd12));
    vt.push_back(mk(0, 0, 1, 1, 16'h0002, 0, 8'd0,   8'd11,  8'd8,   0, 1, 0, 4'd12));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd12,  8'd11,  1, 1, 0, 4'd13));
    vt.push_back(mk(0, 0, 0, 1, 16'h0005, 1, 8'd40,  8'd40,  8'd11,  0, 1, 0, 4'd13));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd41,  8'd40,  1, 1, 0, 4'd14));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd42,  8'd41,  1, 1, 0, 4'd15));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 8'd0,   8'd43,  8'd42,  1, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 8'd254, 8'd254, 8'd42,  0, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd255, 8'd254, 1, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd0,   8'd255, 1, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 8'd250, 8'd250, 8'd255, 0, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd251, 8'd250, 1, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 1, 16'h000A, 0, 8'd0,   8'd5,   8'd250, 0, 1, 0, 4'd15));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 8'd0,   8'd6,   8'd5,   1, 1, 0, 4'd15));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].s, vt[i].st, vt[i].b, vt[i].o, vt[i].j, vt[i].t);
      step();
      chk($sformatf("v%0d pc", i),      32'(bus.imem_addr),   32'(vt[i].pc));
      chk($sformatf("v%0d ifid_pc", i), 32'(bus.ifid_pc),     32'(vt[i].ipc));
      chk($sformatf("v%0d instr", i),   bus.ifid_instr,       32'(vt[i].ipc));
      chk($sformatf("v%0d valid", i),   32'(bus.ifid_valid),  32'(vt[i].vld));
      chk($sformatf("v%0d running", i), 32'(bus.running),     32'(vt[i].run));
      chk($sformatf("v%0d halted", i),  32'(bus.halted),      32'(vt[i].hlt));
      chk($sformatf("v%0d count", i),   32'(bus.fetch_count), 32'(vt[i].cnt));
    end

    // Halt: opcode 6'h3F word at address 7; a stall on that word must defer the halt.
    mem[7] = 32'hFC00_0007;
    drive(1, 0, 0, 0, 16'h0, 0, 8'h0); step();
    chk_reset("halt pre-rst");
    drive(0, 1, 0, 0, 16'h0, 0, 8'h0); step();
    drive(0, 0, 0, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 7; i++) step();
    chk("halt reach pc", 32'(bus.imem_addr), 32'd7);
    drive(0, 0, 1, 0, 16'h0, 0, 8'h0); step();
    chk("halt stall pc",     32'(bus.imem_addr), 32'd7);
    chk("halt stall halted", 32'(bus.halted),    32'd0);
    chk("halt stall ifid",   32'(bus.ifid_pc),   32'd6);
    drive(0, 0, 0, 0, 16'h0, 0, 8'h0); step();
    chk("halt halted",  32'(bus.halted),      32'd1);
    chk("halt running", 32'(bus.running),     32'd0);
    chk("halt instr",   bus.ifid_instr,       32'hFC00_0007);
    chk("halt ifid_pc", 32'(bus.ifid_pc),     32'd7);
    chk("halt valid",   32'(bus.ifid_valid),  32'd1);
    chk("halt pc",      32'(bus.imem_addr),   32'd7);
    chk("halt count",   32'(bus.fetch_count), 32'd8);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1'(i % 2), 1, 16'h0003, 1, 8'd40); step();
      chk($sformatf("halted%0d pc", i),    32'(bus.imem_addr),   32'd7);
      chk($sformatf("halted%0d valid", i), 32'(bus.ifid_valid),  32'd0);
      chk($sformatf("halted%0d state", i), 32'(bus.halted),      32'd1);
      chk($sformatf("halted%0d instr", i), bus.ifid_instr,       32'hFC00_0007);
      chk($sformatf("halted%0d count", i), 32'(bus.fetch_count), 32'd8);
    end
    drive(1, 1, 0, 0, 16'h0, 1, 8'd40); step();
    chk_reset("halt rst");
    mem[7] = 32'd7;

    // Saturation of the 4-bit counter, then reset asserted mid-run with other inputs active.
    drive(0, 1, 0, 0, 16'h0, 0, 8'h0); step();
    drive(0, 0, 0, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 20; i++) step();
    chk("sat count",   32'(bus.fetch_count), 32'd15);
    chk("sat pc",      32'(bus.imem_addr),   32'd20);
    chk("sat ifid_pc", 32'(bus.ifid_pc),     32'd19);
    drive(1, 1, 0, 0, 16'h0, 1, 8'd33); step();
    chk_reset("midrun rst");
    drive(0, 0, 0, 0, 16'h0, 0, 8'h0); step();
    chk("idle hold pc",      32'(bus.imem_addr), 32'd0);
    chk("idle hold running", 32'(bus.running),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and instruction-fetch stage; next generation of the processor-top PC/branch logic.
- Drives instruction-memory address, captures the fetched word into an IF/ID pipeline register, and applies stall, branch, jump, flush and halt control.
- Sits between the instruction memory and the decode/control stage of the pipelined processor.

Parameters:
- ADDR_W, 6: PC / instruction-memory address width.
- INSTR_W, 32: instruction width.
- OFF_W, 16: branch offset width, two's complement.
- RESET_PC, 0: PC value loaded on reset.
- HALT_OP, 6'h3F: opcode in instr[INSTR_W-1:INSTR_W-6] that halts fetch.
- COUNT_W, 16: fetch counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  leave IDLE and begin fetching.
- stall  in  1  hold PC and IF/ID register.
- branch_taken  in  1  redirect to ifid_pc + 1 + sext(branch_offset).
- branch_offset  in  OFF_W  signed branch offset.
- jump  in  1  redirect to jump_target.
- jump_target  in  ADDR_W  absolute jump address.
- imem_addr  out  ADDR_W  equals PC register; memory read is combinational.
- imem_data  in  INSTR_W  instruction at imem_addr, same cycle.
- ifid_instr  out  INSTR_W  registered instruction.
- ifid_pc  out  ADDR_W  PC of ifid_instr.
- ifid_valid  out  1  ifid_instr is a live instruction.
- running  out  1  state == RUN.
- halted  out  1  state == HALTED.
- fetch_count  out  COUNT_W  valid instructions loaded into IF/ID, saturating.

Behaviour:
- Reset (rst=1 at edge, any state, mid-operation included):
  - pc=RESET_PC; ifid_instr=0; ifid_pc=0; ifid_valid=0; fetch_count=0; state=IDLE.
  - rst overrides every other input.
- FSM states: IDLE, RUN, HALTED.
  - IDLE: pc held; ifid_valid=0. start=1 -> RUN next cycle. No fetch in the start cycle.
  - RUN: fetch per the priority list below.
  - HALTED: pc, ifid_instr and ifid_pc held; ifid_valid=0 from the cycle after entry. start, stall, branch_taken and jump are ignored. Only rst exits.
- RUN priority per cycle, highest first:
  1. Jump (jump=1): pc <= jump_target; ifid_valid <= 0 (flush).
  2. Branch (branch_taken=1, jump=0): pc <= ifid_pc + 1 + sext(branch_offset), computed modulo 2^ADDR_W; ifid_valid <= 0.
  3. Stall (stall=1, no redirect): pc and all IF/ID fields held; fetch_count held.
  4. Halt (imem_data opcode == HALT_OP, none of the above):
     - ifid_instr <= imem_data; ifid_pc <= pc; ifid_valid <= 1; fetch_count increments.
     - pc held; state -> HALTED.
  5. Sequential: ifid_instr <= imem_data; ifid_pc <= pc; ifid_valid <= 1; pc <= pc + 1 (wraps 2^ADDR_W-1 -> 0); fetch_count increments.
- A redirect wins over stall and over halt detection in the same cycle. The flushed slot does not count.
- branch_taken and jump are sampled only in RUN. Upstream must assert branch_taken only while ifid_valid=1.
- fetch_count saturates at 2^COUNT_W-1; it does not wrap.
- All outputs are registered or derived from state/pc only; imem_addr has no combinational path from inputs.

Test Plan:
- Boot (ADDR_W=8, imem_data=address): rst, then start pulse, then 4 cycles -> ifid_pc 0,1,2,3; ifid_valid=1; running=1; fetch_count=4; imem_addr=4.
- Branch with ifid_pc=5, branch_taken=1, offset=-3 (16'hFFFD) -> next cycle pc=3, ifid_valid=0; following cycle ifid_pc=3, ifid_valid=1.
- Wrap: pc=255 sequential -> pc=0. Branch from ifid_pc=250 with offset=+10 -> pc=5.
- Stall held 3 cycles at pc=9 -> pc, ifid_* and fetch_count unchanged. Stall+branch in the same cycle -> branch taken and slot flushed. Jump+branch in the same cycle with jump_target=40 -> pc=40.
- Halt: HALT_OP word at address 7 -> ifid_instr=that word, ifid_pc=7, halted=1 next cycle. pc stays 7 for 10 cycles; jump ignored; ifid_valid=0. rst -> pc=0, IDLE, halted=0.
- Saturation (COUNT_W=4): 20 sequential fetches -> fetch_count=15. rst asserted mid-run -> all outputs return to reset values on the next edge.
